// File: rtl/tone_gen_top_if.sv
// Board-side signal bundle for the tone generator: push buttons and switches in,
// status LEDs and the amplifier PWM/enable lines out.
interface tone_gen_top_if;
    logic [3:0] BUTTONS;
    logic [1:0] SWITCHES;
    logic [5:0] LEDS;
    logic       aud_pwm;
    logic       aud_sd;

    // Board (or testbench) view: drives the user inputs, observes the outputs.
    modport master (
        output BUTTONS,
        output SWITCHES,
        input  LEDS,
        input  aud_pwm,
        input  aud_sd
    );

    // Tone generator view.
    modport slave (
        input  BUTTONS,
        input  SWITCHES,
        output LEDS,
        output aud_pwm,
        output aud_sd
    );
endinterface

// File: rtl/tone_gen_top.sv
// Square-wave tone generator with PWM audio output.
// A button picks the tone half-period; a tone counter flips a phase bit every
// half-period; a free-running PWM frame counter latches a sample code from the
// phase at each frame start and drives aud_pwm high for `code` cycles per frame.
module tone_gen_top #(
    parameter int CLK_HZ      = 125_000_000,
    parameter int SAMPLE_CLKS = 2500,
    parameter int PWM_MID     = 1250,
    parameter int AMP_FULL    = 1000,
    parameter int AMP_HALF    = 500
) (
    input  logic          CLK_125MHZ_FPGA,
    input  logic          RESET_N,
    tone_gen_top_if.slave board
);

    // Half-period in clocks, rounded to nearest: round(CLK_HZ / (2 * f)).
    function automatic int half_period(input int freq_hz);
        return (CLK_HZ + freq_hz) / (2 * freq_hz);
    endfunction

    localparam logic [17:0] HP_262  = 18'(half_period(262));
    localparam logic [17:0] HP_330  = 18'(half_period(330));
    localparam logic [17:0] HP_392  = 18'(half_period(392));
    localparam logic [17:0] HP_523  = 18'(half_period(523));
    localparam logic [17:0] HP_440  = 18'(half_period(440));

    localparam logic [11:0] MID      = 12'(PWM_MID);
    localparam logic [11:0] AMP_F    = 12'(AMP_FULL);
    localparam logic [11:0] AMP_H    = 12'(AMP_HALF);
    localparam logic [11:0] PWM_LAST = 12'(SAMPLE_CLKS - 1);

    logic [3:0]  btn_s1, btn_s2;
    logic [1:0]  sw_s1, sw_s2;
    logic [3:0]  sel, sel_q;
    logic [17:0] hp;
    logic [17:0] tone_cnt;
    logic        phase;
    logic [11:0] pwm_cnt;
    logic [11:0] code, code_next, frame_code, amp;
    logic        aud_pwm_q, aud_sd_q, led_phase, led_mute;

    wire mute = sw_s2[0];
    wire half = sw_s2[1];

    // Two-flop synchronisers for the asynchronous buttons and switches.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK_125MHZ_FPGA) begin
        if (!RESET_N) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= board.BUTTONS;
            btn_s2 <= btn_s1;
            sw_s1  <= board.SWITCHES;
            sw_s2  <= sw_s1;
        end
    end

    // Priority tone select: lowest pressed button wins, none pressed gives 440 Hz.
    // NOTE: defaults assigned first so no path leaves sel/hp unassigned (no latch).
    always_comb begin
        sel = 4'b0000;
        hp  = HP_440;
        if (btn_s2[0]) begin
            sel = 4'b0001;
            hp  = HP_262;
        end else if (btn_s2[1]) begin
            sel = 4'b0010;
            hp  = HP_330;
        end else if (btn_s2[2]) begin
            sel = 4'b0100;
            hp  = HP_392;
        end else if (btn_s2[3]) begin
            sel = 4'b1000;
            hp  = HP_523;
        end
    end

    // Tone counter: restarts on a tone change (phase kept), else wraps at HP-1 and flips phase.
    always_ff @(posedge CLK_125MHZ_FPGA) begin
        if (!RESET_N) begin
            tone_cnt <= '0;
            phase    <= 1'b0;
            sel_q    <= '0;
        end else begin
            sel_q <= sel;
            if (sel != sel_q) begin
                tone_cnt <= '0;
            end else if (tone_cnt == hp - 18'd1) begin
                tone_cnt <= '0;
                phase    <= ~phase;
            end else begin
                tone_cnt <= tone_cnt + 18'd1;
            end
        end
    end

    // Sample code for the frame about to start; the current frame uses the latched one.
    always_comb begin
        amp        = half ? AMP_H : AMP_F;
        code_next  = phase ? (MID + amp) : (MID - amp);
        frame_code = (pwm_cnt == 12'd0) ? code_next : code;
    end

    // PWM frame counter (runs through mute) and per-frame code latch.
    always_ff @(posedge CLK_125MHZ_FPGA) begin
        if (!RESET_N) begin
            pwm_cnt <= '0;
            code    <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? 12'd0 : pwm_cnt + 12'd1;
            if (pwm_cnt == 12'd0) begin
                code <= code_next;
            end
        end
    end

    // Registered board outputs: PWM bit, amplifier enable and status LEDs.
    always_ff @(posedge CLK_125MHZ_FPGA) begin
        if (!RESET_N) begin
            aud_pwm_q <= 1'b0;
            aud_sd_q  <= 1'b0;
            led_phase <= 1'b0;
            led_mute  <= 1'b0;
        end else begin
            aud_pwm_q <= (pwm_cnt < frame_code) && !mute;
            aud_sd_q  <= !mute;
            led_phase <= phase;
            led_mute  <= mute;
        end
    end

    assign board.aud_pwm = aud_pwm_q;
    assign board.aud_sd  = aud_sd_q;
    assign board.LEDS    = {led_mute, led_phase, sel_q};

endmodule

// File: tb/tb_tone_gen_top.sv
// Self-checking bench for tone_gen_top, run with scaled-down clock parameters so
// several tone half-periods fit in a short run. A reference model of the tone
// phase and frame timing pushes each frame's expected high count to a queue at
// frame start; a monitor counts aud_pwm per frame and pops/compares at frame end.
module tb_tone_gen_top;

    localparam int CLK_HZ = 1_250_000;
    localparam int N      = 100;
    localparam int MID    = 50;
    localparam int AF     = 40;
    localparam int AH     = 20;

    // round(CLK_HZ / (2 f)) for the scaled clock
    localparam int HP_262 = 2385;
    localparam int HP_330 = 1894;
    localparam int HP_392 = 1594;
    localparam int HP_523 = 1195;
    localparam int HP_440 = 1420;

    localparam int WAIT_BOUND = 3000;

    logic clk = 1'b0;
    logic RESET_N;
    tone_gen_top_if bus ();

    tone_gen_top #(
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_CLKS(N),
        .PWM_MID    (MID),
        .AMP_FULL   (AF),
        .AMP_HALF   (AH)
    ) dut (
        .CLK_125MHZ_FPGA(clk),
        .RESET_N        (RESET_N),
        .board          (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] onehot_of(input logic [3:0] b);
        if (b[0]) return 4'b0001;
        if (b[1]) return 4'b0010;
        if (b[2]) return 4'b0100;
        if (b[3]) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic int hp_of(input logic [3:0] s);
        case (s)
            4'b0001: return HP_262;
            4'b0010: return HP_330;
            4'b0100: return HP_392;
            4'b1000: return HP_523;
            default: return HP_440;
        endcase
    endfunction

    int         m_tcnt = 0;
    int         m_pwm  = 0;
    bit         m_phase = 1'b0;
    logic [3:0] m_b1 = '0, m_b2 = '0, m_sel = '0, m_s;
    logic [1:0] m_w1 = '0, m_w2 = '0;
    int         m_hp;
    bit         sb_en = 1'b0;
    int         sb_q[$];

    always @(posedge clk) begin
        if (!RESET_N) begin
            m_tcnt = 0; m_pwm = 0; m_phase = 1'b0;
            m_b1 = '0; m_b2 = '0; m_sel = '0; m_w1 = '0; m_w2 = '0;
        end else begin
            m_s  = onehot_of(m_b2);
            m_hp = hp_of(m_s);
            if (m_pwm == 0 && sb_en)
                sb_q.push_back(m_w2[0] ? 0 : (m_phase ? MID + (m_w2[1] ? AH : AF)
                                                      : MID - (m_w2[1] ? AH : AF)));
            if (m_s != m_sel) m_tcnt = 0;
            else if (m_tcnt == m_hp - 1) begin m_tcnt = 0; m_phase = !m_phase; end
            else m_tcnt++;
            m_pwm = (m_pwm == N - 1) ? 0 : m_pwm + 1;
            m_sel = m_s;
            m_b2 = m_b1; m_b1 = bus.BUTTONS;
            m_w2 = m_w1; m_w1 = bus.SWITCHES;
        end
    end

    // ---------------- frame monitor (samples on the falling edge) ----------------
    int acc = 0;
    bit have_frame = 1'b0;

    always @(negedge clk) begin
        if (m_pwm == 1) begin
            if (have_frame && sb_en) begin
                if (sb_q.size() == 0) check("frame_queue_empty", 1, 0);
                else check("frame_count", acc, sb_q.pop_front());
            end
            have_frame = sb_en;
            acc = int'(bus.aud_pwm);
        end else begin
            acc += int'(bus.aud_pwm);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Change switches so the synchronised value lands exactly on a frame start.
    task automatic set_switches(input logic [1:0] v);
        do begin @(posedge clk); #1; end while (m_pwm != N - 2);
        bus.SWITCHES = v;
    endtask

    // Count clock edges until LEDS[4] changes, bounded.
    task automatic wait_toggle(output int n);
        logic old;
        old = bus.LEDS[4];
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (bus.LEDS[4] == old && n < WAIT_BOUND);
    endtask

    int n;

    initial begin
        RESET_N = 1'b0;
        bus.BUTTONS  = 4'b0000;
        bus.SWITCHES = 2'b00;

        // 1. reset state
        repeat (10) @(posedge clk);
        #1;
        check("rst_aud_pwm", int'(bus.aud_pwm), 0);
        check("rst_aud_sd",  int'(bus.aud_sd),  0);
        check("rst_leds",    int'(bus.LEDS),    0);
        RESET_N = 1'b1;
        sb_en   = 1'b1;
        @(posedge clk); #1;
        check("sd_after_release", int'(bus.aud_sd), 1);

        // 2. default 440 Hz tone, full volume
        wait_toggle(n);
        check("first_toggle_440", n, HP_440);
        wait_toggle(n);
        check("hp_440", n, HP_440);
        wait_toggle(n);
        check("hp_440_b", n, HP_440);
        check("leds_default", int'(bus.LEDS[3:0]), 0);

        // 3. half volume, same tone period
        set_switches(2'b10);
        wait_toggle(n);
        wait_toggle(n);
        check("hp_440_half", n, HP_440);

        // 4. mute
        set_switches(2'b01);
        repeat (5) @(posedge clk);
        #1;
        check("mute_sd",   int'(bus.aud_sd),  0);
        check("mute_led",  int'(bus.LEDS[5]), 1);
        check("mute_pwm",  int'(bus.aud_pwm), 0);
        repeat (300) @(posedge clk);
        set_switches(2'b00);
        repeat (5) @(posedge clk);
        #1;
        check("unmute_sd",  int'(bus.aud_sd),  1);
        check("unmute_led", int'(bus.LEDS[5]), 0);

        // 5. button select and priority
        bus.BUTTONS = 4'b0100;
        repeat (4) @(posedge clk);
        #1;
        check("leds_btn2", int'(bus.LEDS[3:0]), 4'b0100);
        wait_toggle(n);
        wait_toggle(n);
        check("hp_392", n, HP_392);
        bus.BUTTONS = 4'b0101;
        repeat (4) @(posedge clk);
        #1;
        check("leds_prio", int'(bus.LEDS[3:0]), 4'b0001);
        wait_toggle(n);
        wait_toggle(n);
        check("hp_262", n, HP_262);

        // 6. tone change mid-half-period restarts the counter, phase untouched
        repeat (500) @(posedge clk);
        #1;
        bus.BUTTONS = 4'b0010;
        wait_toggle(n);
        check("restart_330", n, HP_330 + 4);
        check("leds_btn1", int'(bus.LEDS[3:0]), 4'b0010);

        // reset mid-operation, then realignment
        sb_en = 1'b0;
        have_frame = 1'b0;
        sb_q.delete();
        RESET_N = 1'b0;
        @(posedge clk); #1;
        check("midrst_leds", int'(bus.LEDS),    0);
        check("midrst_sd",   int'(bus.aud_sd),  0);
        check("midrst_pwm",  int'(bus.aud_pwm), 0);
        bus.BUTTONS = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        RESET_N = 1'b1;
        sb_en   = 1'b1;
        @(posedge clk); #1;
        check("midrst_release_sd", int'(bus.aud_sd), 1);
        wait_toggle(n);
        check("midrst_phase_restart", n, HP_440);
        repeat (3 * N) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
